// File: rtl/bram_test_sequencer.sv
// Run sequencer for the BRAM pattern tester: issues N xorshift32 seeds, collects per-run
// status under a timeout, and returns one summary word. SEQ_FAIL_LOG_EN adds first-fail seed capture.
module bram_test_sequencer #(
    parameter logic [31:0] SEED_INIT      = 32'h1234_5678,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_tvalid,
    output logic        cmd_tready,
    input  logic [31:0] cmd_tdata,
    output logic        seed_tvalid,
    input  logic        seed_tready,
    output logic [31:0] seed_tdata,
    input  logic        status_tvalid,
    output logic        status_tready,
    input  logic [31:0] status_tdata,
    output logic        result_tvalid,
    input  logic        result_tready,
    output logic [31:0] result_tdata,
    output logic        busy,
    output logic [31:0] first_fail_seed
);
    typedef enum logic [1:0] {IDLE, SEND_SEED, WAIT_DONE, REPORT} state_t;

    state_t      state_q, state_d;
    logic [31:0] seed_q, seed_d;
    logic [15:0] n_q, n_d;
    logic [15:0] runs_q, runs_d;
    logic [13:0] fail_q, fail_d;
    logic [13:0] fail_nxt;
    logic [31:0] timer_q, timer_d;
    logic        timeout_q, timeout_d;
    logic [31:0] result_q, result_d;
    logic        cmd_tready_q, seed_tvalid_q, result_tvalid_q, busy_q;
    logic        status_hs;
    logic        unused_bits;

    function automatic logic [31:0] xorshift32(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    // Tester status is always valid, so readiness is qualified by the done bit.
    assign status_hs     = (state_q == WAIT_DONE) && status_tvalid && status_tdata[1];
    assign status_tready = status_hs;
    assign unused_bits   = ^{cmd_tdata[31:16], status_tdata[31:2]};

    always_comb begin
        state_d   = state_q;
        seed_d    = seed_q;
        n_d       = n_q;
        runs_d    = runs_q;
        fail_d    = fail_q;
        fail_nxt  = fail_q;
        timer_d   = timer_q;
        timeout_d = timeout_q;
        result_d  = result_q;
        case (state_q)
            IDLE: begin
                if (cmd_tvalid) begin
                    n_d       = cmd_tdata[15:0];
                    runs_d    = '0;
                    fail_d    = '0;
                    timeout_d = 1'b0;
                    if (cmd_tdata[15:0] == 16'd0) begin
                        state_d  = REPORT;
                        result_d = {1'b0, 1'b1, 14'd0, 16'd0};
                    end else begin
                        state_d = SEND_SEED;
                    end
                end
            end
            SEND_SEED: begin
                if (seed_tready) begin
                    timer_d = '0;
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // A handshake in the expiry cycle takes priority over the timeout.
                if (status_hs) begin
                    runs_d = runs_q + 16'd1;
                    if (!status_tdata[0] && fail_q != 14'h3FFF)
                        fail_nxt = fail_q + 14'd1;
                    fail_d = fail_nxt;
                    seed_d = xorshift32(seed_q);
                    if (runs_d == n_q) begin
                        state_d  = REPORT;
                        result_d = {1'b0, (fail_nxt == 14'd0) && !timeout_q, fail_nxt, runs_d};
                    end else begin
                        state_d = SEND_SEED;
                    end
                end else if (timer_q == TIMEOUT_CYCLES - 32'd1) begin
                    timeout_d = 1'b1;
                    state_d   = REPORT;
                    result_d  = {1'b1, 1'b0, fail_q, runs_q};
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            REPORT: begin
                if (result_tready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            seed_q          <= SEED_INIT;
            n_q             <= '0;
            runs_q          <= '0;
            fail_q          <= '0;
            timer_q         <= '0;
            timeout_q       <= 1'b0;
            result_q        <= '0;
            cmd_tready_q    <= 1'b1;
            seed_tvalid_q   <= 1'b0;
            result_tvalid_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            seed_q          <= seed_d;
            n_q             <= n_d;
            runs_q          <= runs_d;
            fail_q          <= fail_d;
            timer_q         <= timer_d;
            timeout_q       <= timeout_d;
            result_q        <= result_d;
            cmd_tready_q    <= (state_d == IDLE);
            seed_tvalid_q   <= (state_d == SEND_SEED);
            result_tvalid_q <= (state_d == REPORT);
            busy_q          <= (state_d != IDLE);
        end
    end

    assign cmd_tready    = cmd_tready_q;
    assign seed_tvalid   = seed_tvalid_q;
    assign seed_tdata    = seed_q;
    assign result_tvalid = result_tvalid_q;
    assign result_tdata  = result_q;
    assign busy          = busy_q;

`ifdef SEQ_FAIL_LOG_EN
    logic [31:0] ffs_q, ffs_d;

    // xorshift32 never yields zero from a non-zero seed, so zero marks "nothing captured yet".
    always_comb begin
        ffs_d = ffs_q;
        if (state_q == IDLE && cmd_tvalid)
            ffs_d = '0;
        else if (status_hs && !status_tdata[0] && ffs_q == '0)
            ffs_d = seed_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ffs_q <= '0;
        else          ffs_q <= ffs_d;
    end

    assign first_fail_seed = ffs_q;
`else
    assign first_fail_seed = '0;
`endif

endmodule

// File: tb/tb_bram_test_sequencer.sv
// Self-checking bench for bram_test_sequencer: tester model plus a reference model of seeds,
// pass/fail counts and summary words, driven by directed and randomized commands.
module tb_bram_test_sequencer;
    localparam logic [31:0] SEED0 = 32'h1234_5678;
    localparam int          TMO   = 50;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_tvalid = 1'b0;
    logic        cmd_tready;
    logic [31:0] cmd_tdata = '0;
    logic        seed_tvalid;
    logic        seed_tready = 1'b0;
    logic [31:0] seed_tdata;
    logic        status_tvalid = 1'b0;
    logic        status_tready;
    logic [31:0] status_tdata = '0;
    logic        result_tvalid;
    logic        result_tready = 1'b0;
    logic [31:0] result_tdata;
    logic        busy;
    logic [31:0] first_fail_seed;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] model_seed = SEED0;
    logic [31:0] model_ffs = '0;

    bram_test_sequencer #(
        .SEED_INIT      (SEED0),
        .TIMEOUT_CYCLES (32'(TMO))
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cmd_tvalid      (cmd_tvalid),
        .cmd_tready      (cmd_tready),
        .cmd_tdata       (cmd_tdata),
        .seed_tvalid     (seed_tvalid),
        .seed_tready     (seed_tready),
        .seed_tdata      (seed_tdata),
        .status_tvalid   (status_tvalid),
        .status_tready   (status_tready),
        .status_tdata    (status_tdata),
        .result_tvalid   (result_tvalid),
        .result_tready   (result_tready),
        .result_tdata    (result_tdata),
        .busy            (busy),
        .first_fail_seed (first_fail_seed)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] next_seed(input logic [31:0] x);
        logic [31:0] t;
        t = x;
        t = t ^ (t << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    function automatic logic [31:0] exp_ffs();
`ifdef SEQ_FAIL_LOG_EN
        return model_ffs;
`else
        return 32'h0;
`endif
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [15:0] n);
        logic [31:0] r;
        r = $urandom();
        chk1("cmd_tready_idle", cmd_tready, 1'b1);
        cmd_tvalid = 1'b1;
        cmd_tdata  = {r[31:16], n};
        @(negedge clk);
        cmd_tvalid = 1'b0;
        model_ffs  = '0;
    endtask

    task automatic get_result(input logic [31:0] expres, input int hold);
        int cyc;
        cyc = 0;
        while (result_tvalid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk1("result_tvalid", result_tvalid, 1'b1);
        chk32("result_tdata", result_tdata, expres);
        chk1("cmd_tready_report", cmd_tready, 1'b0);
        chk1("busy_report", busy, 1'b1);
        chk32("first_fail_seed", first_fail_seed, exp_ffs());
        repeat (hold) begin
            @(negedge clk);
            chk32("result_hold", result_tdata, expres);
            chk1("cmd_tready_hold", cmd_tready, 1'b0);
        end
        result_tready = 1'b1;
        @(negedge clk);
        result_tready = 1'b0;
        chk1("result_drop", result_tvalid, 1'b0);
        chk1("idle_ready", cmd_tready, 1'b1);
        chk1("idle_busy", busy, 1'b0);
    endtask

    // fails[i-1] marks run i as failing; hang_at names the run whose done never arrives.
    task automatic run_cmd(input logic [15:0] n, input logic [63:0] fails, input int lat_lo,
                           input int lat_hi, input int hang_at, input int hold);
        int          runs, nfail, lat, cyc;
        logic        timed_out, pass;
        logic [31:0] r, expres;
        logic [13:0] f14;
        runs = 0;
        nfail = 0;
        timed_out = 1'b0;
        send_cmd(n);
        if (n == 16'd0) begin
            chk1("n0_result_now", result_tvalid, 1'b1);
            chk1("n0_no_seed", seed_tvalid, 1'b0);
        end
        for (int i = 1; i <= int'(n) && !timed_out; i++) begin
            cyc = 0;
            while (seed_tvalid !== 1'b1 && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            chk1("seed_tvalid", seed_tvalid, 1'b1);
            chk32("seed_tdata", seed_tdata, model_seed);
            chk1("busy_run", busy, 1'b1);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk32("seed_hold", seed_tdata, model_seed);
            end
            seed_tready = 1'b1;
            @(negedge clk);
            seed_tready = 1'b0;
            chk1("seed_drop", seed_tvalid, 1'b0);
            r = $urandom();
            status_tdata = {r[31:2], 1'b0, r[0]};
            #1 chk1("status_not_done", status_tready, 1'b0);
            if (i == hang_at) begin
                for (int k = 1; k < TMO; k++) begin
                    @(negedge clk);
                    chk1("tmo_wait", result_tvalid, 1'b0);
                    chk1("tmo_status_rdy", status_tready, 1'b0);
                end
                @(negedge clk);
                timed_out = 1'b1;
            end else begin
                lat = int'($urandom_range(lat_lo, lat_hi));
                repeat (lat) begin
                    @(negedge clk);
                    #1 chk1("status_gated", status_tready, 1'b0);
                end
                pass = !fails[i-1];
                status_tdata = {r[31:2], 1'b1, pass};
                #1 chk1("status_tready", status_tready, 1'b1);
                @(negedge clk);
                status_tdata = {r[31:2], 1'b0, r[0]};
                runs++;
                if (!pass) begin
                    if (nfail == 0) model_ffs = model_seed;
                    nfail++;
                end
                model_seed = next_seed(model_seed);
            end
        end
        f14 = (nfail > 16383) ? 14'h3FFF : 14'(nfail);
        expres = {timed_out, (nfail == 0) && !timed_out, f14, 16'(runs)};
        get_result(expres, hold);
    endtask

    initial begin
        status_tvalid = 1'b1;
        repeat (3) @(negedge clk);
        chk1("rst_cmd_tready", cmd_tready, 1'b1);
        chk1("rst_seed_tvalid", seed_tvalid, 1'b0);
        chk1("rst_result_tvalid", result_tvalid, 1'b0);
        chk32("rst_result_tdata", result_tdata, 32'h0);
        chk1("rst_busy", busy, 1'b0);
        chk32("rst_seed", seed_tdata, SEED0);
        chk32("rst_ffs", first_fail_seed, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        status_tdata = 32'h3;
        #1 chk1("idle_status_rdy", status_tready, 1'b0);
        status_tdata = 32'h0;

        run_cmd(16'd3, 64'h0, 10, 10, 0, 0);
        chk32("three_run_seed", model_seed, next_seed(next_seed(next_seed(SEED0))));
        run_cmd(16'd4, 64'hA, 2, 6, 0, 0);
        run_cmd(16'd2, 64'h0, 0, 0, 1, 0);
        run_cmd(16'd3, 64'h1, 0, 3, 2, 1);
        run_cmd(16'd0, 64'h0, 0, 0, 0, 0);
        run_cmd(16'd1, 64'h0, TMO - 1, TMO - 1, 0, 0);
        run_cmd(16'd1, 64'h1, 20, 20, 0, 5);

        for (int t = 0; t < 8; t++)
            run_cmd(16'($urandom_range(1, 6)), {$urandom(), $urandom()}, 0, 12, 0,
                    int'($urandom_range(0, 3)));

        send_cmd(16'd3);
        seed_tready = 1'b1;
        @(negedge clk);
        seed_tready = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        status_tdata = 32'h3;
        #1;
        chk1("arst_cmd_tready", cmd_tready, 1'b1);
        chk1("arst_seed_tvalid", seed_tvalid, 1'b0);
        chk1("arst_status_tready", status_tready, 1'b0);
        chk1("arst_result_tvalid", result_tvalid, 1'b0);
        chk32("arst_result_tdata", result_tdata, 32'h0);
        chk1("arst_busy", busy, 1'b0);
        chk32("arst_seed", seed_tdata, SEED0);
        chk32("arst_ffs", first_fail_seed, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        status_tdata = 32'h0;
        model_seed = SEED0;
        model_ffs = '0;
        @(negedge clk);
        run_cmd(16'd2, 64'h2, 0, 4, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bram_test_sequencer.md
Name: bram_test_sequencer

Overview:
- Upstream driver and result collector for the BRAM pattern tester.
- Accepts a run command from the processor-side AXI-stream and issues N successive seeds to the tester over its seed stream.
- Consumes each per-run status word, accumulates pass/fail counts, guards each run with a timeout, and returns one summary word on a result stream.

Parameters:
- SEED_INIT, 32'h1234_5678, seed value after reset; must be non-zero.
- TIMEOUT_CYCLES, 32'd100_000, maximum cycles to wait for a run's done status before aborting.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_tvalid  in  1  run command valid
- cmd_tready  out  1  high in IDLE only
- cmd_tdata  in  32  [15:0] run count N; [31:16] ignored
- seed_tvalid  out  1  seed to tester valid
- seed_tready  in  1  tester accepts seed
- seed_tdata  out  32  current seed
- status_tvalid  in  1  tester status valid
- status_tready  out  1  status acknowledge to tester
- status_tdata  in  32  [1] run done, [0] run passed; rest ignored
- result_tvalid  out  1  summary valid
- result_tready  in  1  summary accepted
- result_tdata  out  32  [31] timeout, [30] all passed, [29:16] fail count, [15:0] runs completed
- busy  out  1  high in any state other than IDLE
- first_fail_seed  out  32  see Optional Feature

Behaviour:
- Reset values:
  - state IDLE
  - seed = SEED_INIT
  - run/fail counters 0; timeout counter 0
  - all tvalid/tready outputs 0 except cmd_tready = 1
  - result_tdata = 0; busy = 0
- States: IDLE, SEND_SEED, WAIT_DONE, REPORT.
- IDLE:
  - cmd_tready = 1.
  - On cmd handshake, latch N and clear the run counter, fail counter and timeout flag.
  - N == 0: go to REPORT; result = runs 0, fail 0, all-passed 1.
  - N != 0: go to SEND_SEED.
- SEND_SEED:
  - seed_tvalid = 1; seed_tdata = seed register, stable until handshake.
  - On seed_tvalid && seed_tready: clear the timeout counter and go to WAIT_DONE.
- WAIT_DONE:
  - status_tready = status_tvalid && status_tdata[1], combinational, asserted only in this state. The tester's status stream is always valid, so the ready must be gated by the done bit.
  - On that handshake:
    - run counter += 1.
    - If status_tdata[0] == 0, fail counter += 1; it saturates at 14'h3FFF.
    - Seed advances by xorshift32 (x ^= x<<13; x ^= x>>17; x ^= x<<5, in order, 32-bit wrap).
    - Go to REPORT if the new run count == N, else SEND_SEED.
  - Timeout counter increments each cycle without a handshake. On reaching TIMEOUT_CYCLES-1 with no handshake: set the timeout flag and go to REPORT. The run counter is not incremented and the seed is not advanced.
  - A handshake in the same cycle as timeout expiry wins: the run is counted and the timeout flag stays clear.
- REPORT:
  - result_tvalid = 1; result_tdata is registered and stable until the handshake.
  - all-passed = (fail == 0) && !timeout.
  - On result_tready, return to IDLE.
- Seed register persists across commands; it is reloaded only by reset.
- Asynchronous reset in any state returns all outputs to their reset values immediately. A pending seed or status handshake is abandoned.
- One-cycle turnaround: a REPORT→IDLE→command sequence is legal back-to-back.

Optional Feature:
- Macro: SEQ_FAIL_LOG_EN.
- Defined:
  - A 32-bit register captures the seed of the first failing run since the last command accept (cleared to 0 at command accept) and drives first_fail_seed.
  - Later failures do not overwrite it. Reset value is 0.
- Undefined: first_fail_seed is tied to 32'h0 and no capture logic is synthesised.

Test Plan:
- Reset, cmd N=3, tester model always passes with a 10-cycle run latency:
  - three seeds issued: SEED_INIT, then xorshift32(SEED_INIT), then its successor;
  - result_tdata = 32'h4000_0003.
- cmd N=4, model fails runs 2 and 4:
  - result_tdata = 32'h0002_0004;
  - with SEQ_FAIL_LOG_EN, first_fail_seed = seed of run 2.
- TIMEOUT_CYCLES=50, model never asserts done:
  - abort 50 cycles after the seed handshake;
  - result_tdata = 32'h8000_0000 for N=2.
- cmd N=0:
  - no seed_tvalid pulse;
  - result_tdata = 32'h4000_0000 in the cycle after the command.
- status_tdata[1]=0 held with status_tvalid=1 for 20 cycles: status_tready stays 0. Hold result_tready low 5 cycles: result_tdata stable and cmd_tready stays 0.
- Assert reset_n low mid WAIT_DONE:
  - outputs return to their reset values asynchronously;
  - the next command restarts from SEED_INIT.
